instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Control-sequencing stage directly upstream of the instruction decoder.
- Generates the one-hot FETCH/EXEC1/EXEC2 cycle strobes that the decoder consumes.
- Captures the instruction word from RAM into the instruction register and splits it into opcode (IR) and operand (N).
- Honours the decoder's EXTRA request for a third cycle, halts on STP, and supports the decoder's pipelined early-fetch so that IR is valid during FETCH.

Parameters:
- DATA_W, 16, RAM word width.
- OP_W, 4, opcode width taken from the word MSBs.
- N_W, DATA_W-OP_W, operand width taken from the word LSBs.
- STP_OP, 4'b0111, opcode that halts the machine.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  level; starts or resumes execution from IDLE or HALT.
- ram_q  input  DATA_W  RAM read data, valid during FETCH and at the final exec cycle when pipelining.
- EXTRA  input  1  from decoder; request EXEC2 after EXEC1.
- can_pipe  input  1  from decoder; current cycle is a pipelinable final exec cycle.
- FETCH  output  1  first-cycle strobe.
- EXEC1  output  1  second-cycle strobe.
- EXEC2  output  1  third-cycle strobe.
- IR  output  OP_W  registered opcode.
- N  output  N_W  registered operand.
- HALTED  output  1  machine stopped on STP.
- busy  output  1  high in FETCH, EXEC1 or EXEC2.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset state: IDLE. FETCH=EXEC1=EXEC2=0, IR=0, N=0, HALTED=0, busy=0. Counters (if built) are 0.
- States: IDLE, S_FETCH, S_EX1, S_EX2, S_HALT. Outputs are decoded from registered state, so they are glitch-free and at most one strobe is high in any cycle.
- IDLE: move to S_FETCH when run=1, otherwise stay.
- S_FETCH:
  - If the previous cycle did not load IR via the pipeline path, load IR<=ram_q[DATA_W-1:N_W] and N<=ram_q[N_W-1:0] at the closing edge.
  - Always move to S_EX1.
- S_EX1:
  - If IR==STP_OP, go to S_HALT (STP takes precedence over EXTRA).
  - Otherwise, if EXTRA=1, go to S_EX2.
  - Otherwise, go to S_FETCH.
- S_EX2: go to S_FETCH unconditionally.
- Pipeline load:
  - When can_pipe=1 in S_EX1 or S_EX2 and that cycle exits to S_FETCH, capture IR/N from ram_q at that edge and set an internal pipe_loaded flag.
  - In the following S_FETCH, pipe_loaded=1 suppresses the normal capture; the decoder therefore sees the new opcode for the whole FETCH. The flag clears on leaving S_FETCH.
  - can_pipe in S_FETCH or in a cycle going to S_HALT is ignored.
- S_HALT: HALTED=1, no strobes, IR/N held. Go to S_FETCH on run=1 (a rising level is not required); HALTED drops on that edge.
- Latency: non-EXTRA instruction takes 2 cycles; EXTRA instruction takes 3; STP takes 2 and then stops.
- Reset mid-instruction: returns to IDLE immediately and asynchronously, clears pipe_loaded. Opcode from a partially fetched word is discarded.
- Unknown or unused opcodes: no special handling; they take the 2-cycle path unless EXTRA is asserted.
- Simultaneous STP and can_pipe: STP wins; no pipeline load.

Optional Feature:
- Macro: INSTR_SEQUENCER_PERF_EN.
- Defined:
  - Adds output cycle_cnt (32 bits), incremented every clock while busy=1.
  - Adds output instr_cnt (32 bits), incremented on each transition into S_FETCH from S_EX1/S_EX2 and on entry to S_HALT.
  - Both counters wrap modulo 2^32 and are cleared by rst_n only.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package: state enum (IDLE, S_FETCH, S_EX1, S_EX2, S_HALT), opcode constants (LDA=0 … STP=7, LDI=8, LSR=10, ASR=11), DATA_W/OP_W defaults. The decoder reuses the opcode constants.
- One natural sub-module: instr_reg (IR/N register with load-enable and the pipe_loaded suppression flag). The FSM stays in the top module.

Test Plan:
- Reset then run=1, ram_q=16'h0005 (LDA 5), EXTRA=1 in EX1 -> strobes FETCH,EXEC1,EXEC2,FETCH on consecutive cycles; IR=0, N=5 from the first EXEC1 onward.
- ram_q=16'h4020 (JMP), EXTRA=0 -> FETCH,EXEC1,FETCH; no EXEC2 pulse.
- ram_q=16'h7000 (STP) -> after EXEC1, HALTED=1 and no strobes for 10 cycles; run=1 -> FETCH next cycle, HALTED=0.
- can_pipe=1 in EXEC2 with ram_q=16'h8003 (LDI 3) -> IR=8, N=3 valid during the following FETCH; changing ram_q to 16'hFFFF during that FETCH leaves IR/N unchanged.
- rst_n low asynchronously mid-EXEC1 (between edges) -> all strobes 0 immediately and IR=0; after release, state is IDLE until run.
- INSTR_SEQUENCER_PERF_EN build: run LDA, JMP, STP program -> instr_cnt=3, cycle_cnt=7 at halt.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg
//   Types and constants shared by the instruction sequencer and the decoder.
//   - state_t      : sequencer FSM states
//   - OP_*         : opcode values, also used by the decoder
//   - DEF_DATA_W / DEF_OP_W : default RAM word width and opcode width
package instr_sequencer_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_OP_W   = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_FETCH = 3'd1,
    S_EX1   = 3'd2,
    S_EX2   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JMI = 4'd5;
  localparam logic [3:0] OP_JEQ = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;
  localparam logic [3:0] OP_LDI = 4'd8;
  localparam logic [3:0] OP_LSR = 4'd10;
  localparam logic [3:0] OP_ASR = 4'd11;

endpackage

// File: rtl/instr_sequencer_instr_reg.sv
// instr_sequencer_instr_reg
//   Instruction register: holds opcode (ir) and operand (n) split from a RAM
//   word, plus the pipe_loaded flag that suppresses the normal FETCH capture
//   when the word was already taken at the end of the previous instruction.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_fetch    : sequencer is in S_FETCH this cycle
//   pipe_load   : early-fetch capture at the final exec edge
//   word        : RAM read data
//   ir, n       : registered opcode / operand
module instr_sequencer_instr_reg #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4,
  parameter int N_W    = DATA_W - OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_fetch,
  input  logic              pipe_load,
  input  logic [DATA_W-1:0] word,
  output logic [OP_W-1:0]   ir,
  output logic [N_W-1:0]    n
);

  logic [OP_W-1:0] ir_q, ir_d;
  logic [N_W-1:0]  n_q, n_d;
  logic            pipe_loaded_q, pipe_loaded_d;
  logic            load;

  // FETCH always lasts exactly one cycle, so clearing the flag at the FETCH
  // closing edge is the same as clearing it on leaving S_FETCH.
  assign load = pipe_load | (in_fetch & ~pipe_loaded_q);

  always_comb begin
    ir_d          = ir_q;
    n_d           = n_q;
    pipe_loaded_d = pipe_loaded_q;
    if (load) begin
      ir_d = word[DATA_W-1:N_W];
      n_d  = word[N_W-1:0];
    end
    if (pipe_load) begin
      pipe_loaded_d = 1'b1;
    end else if (in_fetch) begin
      pipe_loaded_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q          <= '0;
      n_q           <= '0;
      pipe_loaded_q <= 1'b0;
    end else begin
      ir_q          <= ir_d;
      n_q           <= n_d;
      pipe_loaded_q <= pipe_loaded_d;
    end
  end

  assign ir = ir_q;
  assign n  = n_q;

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Control sequencer in front of the instruction decoder. Produces one-hot
//   FETCH/EXEC1/EXEC2 strobes, captures the instruction word into IR/N,
//   honours EXTRA (third cycle), halts on STP and supports early fetch
//   (can_pipe) so IR is already valid during FETCH.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   run               : start/resume from IDLE or HALT (level)
//   ram_q             : RAM read data
//   EXTRA, can_pipe   : decoder requests
//   FETCH/EXEC1/EXEC2 : cycle strobes
//   IR, N             : opcode / operand
//   HALTED, busy      : status
//   cycle_cnt, instr_cnt : perf counters, only with INSTR_SEQUENCER_PERF_EN
//
// state   | meaning
// IDLE    | after reset, waiting for run
// S_FETCH | instruction word fetch (IR captured unless early-fetched)
// S_EX1   | first execute cycle
// S_EX2   | optional second execute cycle (EXTRA)
// S_HALT  | stopped on STP, waiting for run
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int              DATA_W = DEF_DATA_W,
  parameter int              OP_W   = DEF_OP_W,
  parameter int              N_W    = DATA_W - OP_W,
  parameter logic [OP_W-1:0] STP_OP = 4'b0111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [DATA_W-1:0] ram_q,
  input  logic              EXTRA,
  input  logic              can_pipe,
  output logic              FETCH,
  output logic              EXEC1,
  output logic              EXEC2,
  output logic [OP_W-1:0]   IR,
  output logic [N_W-1:0]    N,
  output logic              HALTED,
  output logic              busy
`ifdef INSTR_SEQUENCER_PERF_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instr_cnt
`endif
);

  state_t state_q, state_d;
  logic   is_stp;
  logic   exit_to_fetch;
  logic   enter_halt;
  logic   pipe_load;

  assign is_stp = (IR == STP_OP);

  always_comb begin
    state_d       = state_q;
    exit_to_fetch = 1'b0;
    enter_halt    = 1'b0;
    unique case (state_q)
      IDLE:    if (run) state_d = S_FETCH;
      S_FETCH: state_d = S_EX1;
      S_EX1: begin
        if (is_stp) begin
          state_d    = S_HALT;
          enter_halt = 1'b1;
        end else if (EXTRA) begin
          state_d = S_EX2;
        end else begin
          state_d       = S_FETCH;
          exit_to_fetch = 1'b1;
        end
      end
      S_EX2: begin
        state_d       = S_FETCH;
        exit_to_fetch = 1'b1;
      end
      S_HALT:  if (run) state_d = S_FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Early fetch only on a final exec cycle that really returns to FETCH;
  // an STP exit therefore never pipelines.
  assign pipe_load = can_pipe & exit_to_fetch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign FETCH  = (state_q == S_FETCH);
  assign EXEC1  = (state_q == S_EX1);
  assign EXEC2  = (state_q == S_EX2);
  assign HALTED = (state_q == S_HALT);
  assign busy   = FETCH | EXEC1 | EXEC2;

  instr_sequencer_instr_reg #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W),
    .N_W    (N_W)
  ) u_instr_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_fetch  (FETCH),
    .pipe_load (pipe_load),
    .word      (ram_q),
    .ir        (IR),
    .n         (N)
  );

`ifdef INSTR_SEQUENCER_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (busy)                       cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (exit_to_fetch | enter_halt) instr_cnt_d = instr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer
//   Directed self-checking bench for instr_sequencer. Perf counter checks are
//   built only when INSTR_SEQUENCER_PERF_EN is defined.
module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] ram_q;
  logic        EXTRA;
  logic        can_pipe;
  logic        FETCH, EXEC1, EXEC2;
  logic [3:0]  IR;
  logic [11:0] N;
  logic        HALTED, busy;
`ifdef INSTR_SEQUENCER_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  instr_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .ram_q    (ram_q),
    .EXTRA    (EXTRA),
    .can_pipe (can_pipe),
    .FETCH    (FETCH),
    .EXEC1    (EXEC1),
    .EXEC2    (EXEC2),
    .IR       (IR),
    .N        (N),
    .HALTED   (HALTED),
    .busy     (busy)
`ifdef INSTR_SEQUENCER_PERF_EN
    ,
    .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; ram_q = '0; EXTRA = 1'b0; can_pipe = 1'b0;
    tick(); tick();
    total_cnt++;
    if ({FETCH, EXEC1, EXEC2, HALTED, busy} !== 5'b0) $display("FAIL reset_status got=%b exp=00000", {FETCH, EXEC1, EXEC2, HALTED, busy});
    else pass_cnt++;
    total_cnt++;
    if ({IR, N} !== 16'h0000) $display("FAIL reset_irn got=%h exp=0000", {IR, N});
    else pass_cnt++;
    rst_n = 1'b1;
    tick(); tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL idle_hold busy got=%b exp=0", busy);
    else pass_cnt++;
  endtask

  // LDA 5 with EXTRA: FETCH, EXEC1, EXEC2, FETCH
  task automatic test_extra();
    ram_q = 16'h0005; run = 1'b1;
    tick();
    run = 1'b0; EXTRA = 1'b1;
    total_cnt++;
    if ({FETCH, EXEC1, EXEC2} !== 3'b100) $display("FAIL extra_fetch strobes got=%b exp=100", {FETCH, EXEC1, EXEC2});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({FETCH, EXEC1, EXEC2, IR, N} !== {3'b010, 4'h0, 12'h005}) $display("FAIL extra_ex1 got=%b_%h_%h exp=010_0_005", {FETCH, EXEC1, EXEC2}, IR, N);
    else pass_cnt++;
    tick();
    EXTRA = 1'b0; ram_q = 16'h4020;
    total_cnt++;
    if ({FETCH, EXEC1, EXEC2, IR, N} !== {3'b001, 4'h0, 12'h005}) $display("FAIL extra_ex2 got=%b_%h_%h exp=001_0_005", {FETCH, EXEC1, EXEC2}, IR, N);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({FETCH, EXEC1, EXEC2} !== 3'b100) $display("FAIL extra_refetch strobes got=%b exp=100", {FETCH, EXEC1, EXEC2});
    else pass_cnt++;
  endtask

  // JMP 0x020, no EXTRA: FETCH, EXEC1, FETCH
  task automatic test_jmp();
    tick();
    total_cnt++;
    if ({FETCH, EXEC1, EXEC2, IR, N} !== {3'b010, 4'h4, 12'h020}) $display("FAIL jmp_ex1 got=%b_%h_%h exp=010_4_020", {FETCH, EXEC1, EXEC2}, IR, N);
    else pass_cnt++;
    tick();
    ram_q = 16'h7000;
    total_cnt++;
    if ({FETCH, EXEC1, EXEC2} !== 3'b100) $display("FAIL jmp_no_ex2 strobes got=%b exp=100", {FETCH, EXEC1, EXEC2});
    else pass_cnt++;
  endtask

  // STP: halt for 10 cycles, then resume with run
  task automatic test_stp();
    tick();
    total_cnt++;
    if ({EXEC1, IR} !== {1'b1, 4'h7}) $display("FAIL stp_ex1 got=%b_%h exp=1_7", EXEC1, IR);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if ({FETCH, EXEC1, EXEC2, HALTED, busy} !== 5'b00010) $display("FAIL stp_halt cyc=%0d got=%b exp=00010", i, {FETCH, EXEC1, EXEC2, HALTED, busy});
      else pass_cnt++;
    end
    run = 1'b1; ram_q = 16'h2001; EXTRA = 1'b1;
    tick();
    run = 1'b0;
    total_cnt++;
    if ({FETCH, HALTED} !== 2'b10) $display("FAIL stp_resume got=%b exp=10", {FETCH, HALTED});
    else pass_cnt++;
  endtask

  // Early fetch of LDI 3 in EXEC2, then STP with can_pipe (STP wins)
  task automatic test_pipeline();
    tick();
    total_cnt++;
    if ({EXEC1, IR, N} !== {1'b1, 4'h2, 12'h001}) $display("FAIL pipe_pre_ex1 got=%b_%h_%h exp=1_2_001", EXEC1, IR, N);
    else pass_cnt++;
    tick();
    can_pipe = 1'b1; ram_q = 16'h8003; EXTRA = 1'b0;
    tick();
    can_pipe = 1'b0;
    total_cnt++;
    if ({FETCH, IR, N} !== {1'b1, 4'h8, 12'h003}) $display("FAIL pipe_fetch got=%b_%h_%h exp=1_8_003", FETCH, IR, N);
    else pass_cnt++;
    ram_q = 16'hFFFF;
    tick();
    total_cnt++;
    if ({EXEC1, IR, N} !== {1'b1, 4'h8, 12'h003}) $display("FAIL pipe_suppress got=%b_%h_%h exp=1_8_003", EXEC1, IR, N);
    else pass_cnt++;
    ram_q = 16'h7000;
    tick();
    tick();
    can_pipe = 1'b1; ram_q = 16'h8003;
    total_cnt++;
    if ({EXEC1, IR} !== {1'b1, 4'h7}) $display("FAIL stp_pipe_ex1 got=%b_%h exp=1_7", EXEC1, IR);
    else pass_cnt++;
    tick();
    can_pipe = 1'b0;
    total_cnt++;
    if ({HALTED, IR, N} !== {1'b1, 4'h7, 12'h000}) $display("FAIL stp_beats_pipe got=%b_%h_%h exp=1_7_000", HALTED, IR, N);
    else pass_cnt++;
  endtask

  // Asynchronous reset in the middle of EXEC1
  task automatic test_async_reset();
    run = 1'b1; ram_q = 16'h3123;
    tick();
    run = 1'b0;
    tick();
    total_cnt++;
    if ({EXEC1, IR} !== {1'b1, 4'h3}) $display("FAIL areset_pre got=%b_%h exp=1_3", EXEC1, IR);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({FETCH, EXEC1, EXEC2, busy, IR, N} !== 20'h0) $display("FAIL areset_immediate got=%b_%h_%h exp=0000_0_000", {FETCH, EXEC1, EXEC2, busy}, IR, N);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    total_cnt++;
    if ({busy, HALTED} !== 2'b00) $display("FAIL areset_idle got=%b exp=00", {busy, HALTED});
    else pass_cnt++;
    run = 1'b1;
    tick();
    run = 1'b0;
    total_cnt++;
    if (FETCH !== 1'b1) $display("FAIL areset_run got=%b exp=1", FETCH);
    else pass_cnt++;
  endtask

`ifdef INSTR_SEQUENCER_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0; run = 1'b0; EXTRA = 1'b0; can_pipe = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    ram_q = 16'h0005; run = 1'b1;
    tick();
    run = 1'b0; EXTRA = 1'b1;
    tick();
    tick();
    EXTRA = 1'b0; ram_q = 16'h4020;
    tick(); tick(); tick();
    ram_q = 16'h7000;
    tick(); tick();
    total_cnt++;
    if ({HALTED, instr_cnt} !== {1'b1, 32'd3}) $display("FAIL perf_instr got=%b_%0d exp=1_3", HALTED, instr_cnt);
    else pass_cnt++;
    total_cnt++;
    if (cycle_cnt !== 32'd7) $display("FAIL perf_cycle got=%0d exp=7", cycle_cnt);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_extra();
    test_jmp();
    test_stp();
    test_pipeline();
    test_async_reset();
`ifdef INSTR_SEQUENCER_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
